// File: rtl/dm_bist_pkg.sv
// Shared types and constants for the dm March C- BIST.
// Build option: DM_BIST_BYTE_EN adds the byte-lane write/read phase.
package dm_bist_pkg;

`ifdef DM_BIST_BYTE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_W0_UP, S_R0W1_UP, S_R1W0_DN, S_R0_DN, S_BW_UP, S_BR_UP, S_DONE
  } state_t;
  // Byte phase walks every byte address, so the index spans 4*DEPTH_WORDS.
  localparam int unsigned IDX_W = 14;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_W0_UP, S_R0W1_UP, S_R1W0_DN, S_R0_DN, S_DONE
  } state_t;
  localparam int unsigned IDX_W = 12;
`endif

  localparam logic [31:0] DEFAULT_PATTERN = 32'h5A5A_A5A5;
  localparam logic [7:0]  BYTE_XOR        = 8'hA5;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dm_bist_addr_gen.sv
// Loadable up/down index counter with terminal-count flag for the dm BIST.
// Terminal count is last_i when counting up and zero when counting down.
module dm_bist_addr_gen #(
  parameter int unsigned W = 14
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = up_i ? cnt_q + W'(1) : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = up_i ? (cnt_q == last_i) : (cnt_q == '0);

endmodule

// File: rtl/dm_bist.sv
// March C- built-in self-test initiator for the data memory.
// Build option: DM_BIST_BYTE_EN appends a byte-lane write/read phase.
module dm_bist
  import dm_bist_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] PATTERN     = DEFAULT_PATTERN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [13:0] fail_addr,
  output logic [31:0] fail_data,
  output logic [13:0] a,
  output logic        wdOp,
  output logic [31:0] wd,
  output logic        we,
  input  logic [31:0] rdw,
  input  logic [7:0]  rdb
);

  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(DEPTH_WORDS - 1);

  state_t state_q, state_d;

  logic [IDX_W-1:0] idx, ld_val, cnt_last;
  logic             ld, cnt_en, cnt_up, tc;
  logic             clear, chk_w, miss;
  logic [31:0]      exp_w, fdata;
  logic [13:0]      word_addr;

  logic [15:0] err_cnt_q;
  logic [13:0] fail_addr_q;
  logic [31:0] fail_data_q;

`ifdef DM_BIST_BYTE_EN
  localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(4 * DEPTH_WORDS - 1);
  logic       chk_b;
  logic [7:0] exp_b;
`endif

  dm_bist_addr_gen #(.W(IDX_W)) u_addr_gen (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (ld),
    .load_val_i (ld_val),
    .en_i       (cnt_en),
    .up_i       (cnt_up),
    .last_i     (cnt_last),
    .cnt_o      (idx),
    .tc_o       (tc)
  );

  assign word_addr = {idx[11:0], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each element hands over to the next on its terminal index and preloads that element's start index.
  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    ld       = 1'b0;
    ld_val   = '0;
    cnt_en   = 1'b0;
    cnt_up   = 1'b1;
    cnt_last = WORD_LAST;
    a        = '0;
    wd       = '0;
    we       = 1'b0;
    chk_w    = 1'b0;
    exp_w    = PATTERN;
`ifdef DM_BIST_BYTE_EN
    wdOp     = 1'b0;
    chk_b    = 1'b0;
    exp_b    = idx[7:0] ^ BYTE_XOR;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_W0_UP;
          clear   = 1'b1;
          ld      = 1'b1;
        end
      end
      S_W0_UP: begin
        cnt_en = 1'b1;
        a      = word_addr;
        we     = 1'b1;
        wd     = PATTERN;
        if (tc) begin
          state_d = S_R0W1_UP;
          ld      = 1'b1;
        end
      end
      S_R0W1_UP: begin
        cnt_en = 1'b1;
        a      = word_addr;
        chk_w  = 1'b1;
        exp_w  = PATTERN;
        we     = 1'b1;
        wd     = ~PATTERN;
        if (tc) begin
          state_d = S_R1W0_DN;
          ld      = 1'b1;
          ld_val  = WORD_LAST;
        end
      end
      S_R1W0_DN: begin
        cnt_en = 1'b1;
        cnt_up = 1'b0;
        a      = word_addr;
        chk_w  = 1'b1;
        exp_w  = ~PATTERN;
        we     = 1'b1;
        wd     = PATTERN;
        if (tc) begin
          state_d = S_R0_DN;
          ld      = 1'b1;
          ld_val  = WORD_LAST;
        end
      end
      S_R0_DN: begin
        cnt_en = 1'b1;
        cnt_up = 1'b0;
        a      = word_addr;
        chk_w  = 1'b1;
        exp_w  = PATTERN;
        if (tc) begin
`ifdef DM_BIST_BYTE_EN
          state_d = S_BW_UP;
`else
          state_d = S_DONE;
`endif
          ld      = 1'b1;
        end
      end
`ifdef DM_BIST_BYTE_EN
      S_BW_UP: begin
        cnt_en   = 1'b1;
        cnt_last = BYTE_LAST;
        a        = idx[13:0];
        we       = 1'b1;
        wdOp     = 1'b1;
        wd       = {24'b0, exp_b};
        if (tc) begin
          state_d = S_BR_UP;
          ld      = 1'b1;
        end
      end
      S_BR_UP: begin
        cnt_en   = 1'b1;
        cnt_last = BYTE_LAST;
        a        = idx[13:0];
        chk_b    = 1'b1;
        if (tc) begin
          state_d = S_DONE;
          ld      = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DM_BIST_BYTE_EN
  assign miss  = (chk_w && (rdw != exp_w)) || (chk_b && (rdb != exp_b));
  assign fdata = chk_b ? {24'b0, rdb} : rdw;
`else
  logic unused_rdb;
  assign unused_rdb = ^rdb;
  assign wdOp  = 1'b0;
  assign miss  = chk_w && (rdw != exp_w);
  assign fdata = rdw;
`endif

  // A zero count marks the next mismatch as the first one, so no separate flag is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (clear) begin
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (miss) begin
      err_cnt_q <= sat_inc(err_cnt_q);
      if (err_cnt_q == '0) begin
        fail_addr_q <= a;
        fail_data_q <= fdata;
      end
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_cnt_q == '0);
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_dm_bist.sv
// Self-checking bench for dm_bist with a behavioural dm (async read, fault injection).
// Build option: DM_BIST_BYTE_EN enables the byte-phase expectations and byte fault scenario.
module tb_dm_bist;

  localparam int          N = 16;
  localparam logic [31:0] P = 32'h5A5A_A5A5;
`ifdef DM_BIST_BYTE_EN
  localparam int TOTAL = 12 * N;
`else
  localparam int TOTAL = 4 * N;
`endif

  logic        clk, reset, start;
  logic        busy, done, pass, wdOp, we;
  logic [15:0] err_cnt;
  logic [13:0] fail_addr, a;
  logic [31:0] fail_data, wd, rdw;
  logic [7:0]  rdb;

  dm_bist #(.DEPTH_WORDS(N), .PATTERN(P)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_data(fail_data),
    .a(a), .wdOp(wdOp), .wd(wd), .we(we), .rdw(rdw), .rdb(rdb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dm: stuck-at-0 bits on one word's read path, dropped byte writes at one byte address.
  logic [31:0] mem [0:N-1];
  int          flt_word = -1;
  logic [31:0] flt_mask = '0;
  int          flt_byte = -1;

  always_comb begin
    logic [31:0] raw;
    raw = mem[a[5:2]];
    if (flt_word == int'(a[5:2])) raw = raw & ~flt_mask;
    rdw = raw;
    rdb = raw[{a[1:0], 3'b000} +: 8];
  end

  always @(posedge clk) begin
    if (we) begin
      if (!wdOp) mem[a[5:2]] <= wd;
      else if (int'(a) != flt_byte) mem[a[5:2]][{a[1:0], 3'b000} +: 8] <= wd[7:0];
    end
  end

  typedef struct packed {
    logic [13:0] a;
    logic        we;
    logic        wdOp;
    logic [31:0] wd;
  } acc_t;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [13:0] fa;
    logic [31:0] fd;
  } res_t;

  acc_t acc_q[$];
  res_t res_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push_acc(input int addr, input logic w, input logic op, input logic [31:0] d);
    acc_t e;
    e.a = 14'(addr); e.we = w; e.wdOp = op; e.wd = d;
    acc_q.push_back(e);
  endtask

  // Independent March C- access sequence, written straight from the algorithm.
  task automatic gen_accesses();
    for (int i = 0; i < N; i++) push_acc(i * 4, 1'b1, 1'b0, P);
    for (int i = 0; i < N; i++) push_acc(i * 4, 1'b1, 1'b0, ~P);
    for (int i = N - 1; i >= 0; i--) push_acc(i * 4, 1'b1, 1'b0, P);
    for (int i = N - 1; i >= 0; i--) push_acc(i * 4, 1'b0, 1'b0, '0);
`ifdef DM_BIST_BYTE_EN
    for (int b = 0; b < 4 * N; b++) begin
      logic [7:0] bb;
      bb = 8'(b);
      push_acc(b, 1'b1, 1'b1, {24'b0, bb ^ 8'hA5});
    end
    for (int b = 0; b < 4 * N; b++) push_acc(b, 1'b0, 1'b0, '0);
`endif
  endtask

  task automatic push_res(input logic p, input logic [15:0] e, input logic [13:0] fa, input logic [31:0] fd);
    res_t r;
    r.pass = p; r.err = e; r.fa = fa; r.fd = fd;
    res_q.push_back(r);
  endtask

  // Runs one full test (or until abort_at), checking every dm access and the final report.
  task automatic run_march(input int abort_at, input bit pulses);
    acc_t exp_a, got_a;
    res_t r;
    gen_accesses();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < TOTAL; k++) begin
      if (k == 0) begin
        n_cmp++;
        if ({done, pass, err_cnt, fail_addr, fail_data} !== '0) begin
          n_bad++;
          $display("FAIL start_clear: got done=%b pass=%b err=%h fa=%h fd=%h want all 0",
                   done, pass, err_cnt, fail_addr, fail_data);
        end
      end
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_cycle%0d: got busy=%b done=%b want busy=1 done=0", k, busy, done);
      end
      n_cmp++;
      if (acc_q.size() == 0) begin
        n_bad++;
        $display("FAIL access_cycle%0d: got a=%h we=%b want no access left", k, a, we);
      end else begin
        exp_a = acc_q.pop_front();
        got_a.a = a; got_a.we = we; got_a.wdOp = wdOp; got_a.wd = we ? wd : '0;
        if (got_a !== exp_a) begin
          n_bad++;
          $display("FAIL access_cycle%0d: got a=%h we=%b op=%b wd=%h want a=%h we=%b op=%b wd=%h",
                   k, got_a.a, got_a.we, got_a.wdOp, got_a.wd, exp_a.a, exp_a.we, exp_a.wdOp, exp_a.wd);
        end
      end
      if (k == abort_at) return;
      start = pulses && (k == 10 || k == 30);
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_latency: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    n_cmp++;
    if (res_q.size() == 0) begin
      n_bad++;
      $display("FAIL result: got a report, want none queued");
    end else begin
      r = res_q.pop_front();
      if (pass !== r.pass || err_cnt !== r.err || fail_addr !== r.fa || fail_data !== r.fd) begin
        n_bad++;
        $display("FAIL result: got pass=%b err=%h fa=%h fd=%h want pass=%b err=%h fa=%h fd=%h",
                 pass, err_cnt, fail_addr, fail_data, r.pass, r.err, r.fa, r.fd);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b1 || we !== 1'b0 || a !== '0) begin
      n_bad++;
      $display("FAIL done_hold: got done=%b we=%b a=%h want done=1 we=0 a=0", done, we, a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, pass, err_cnt, fail_addr, fail_data, a, wdOp, wd, we} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got busy=%b done=%b pass=%b err=%h fa=%h fd=%h a=%h op=%b wd=%h we=%b want all 0",
               busy, done, pass, err_cnt, fail_addr, fail_data, a, wdOp, wd, we);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, we} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b we=%b want 0 0 0", busy, done, we);
    end
  endtask

  task automatic test_clean();
    push_res(1'b1, 16'd0, 14'd0, 32'd0);
    run_march(-1, 1'b0);
    n_cmp++;
`ifdef DM_BIST_BYTE_EN
    if (mem[5] !== 32'hB2B3_B0B1) begin
      n_bad++;
      $display("FAIL mem_word5: got %h want %h", mem[5], 32'hB2B3_B0B1);
    end
`else
    if (mem[5] !== P) begin
      n_bad++;
      $display("FAIL mem_word5: got %h want %h", mem[5], P);
    end
`endif
  endtask

  // Bit 3 is already 0 in P, so only reads of ~P (and byte 0x1C = 0xB9) expose it.
  task automatic test_stuck_bit3();
    flt_word = 7; flt_mask = 32'h8;
`ifdef DM_BIST_BYTE_EN
    push_res(1'b0, 16'd2, 14'h1C, 32'hA5A5_5A52);
`else
    push_res(1'b0, 16'd1, 14'h1C, 32'hA5A5_5A52);
`endif
    run_march(-1, 1'b0);
  endtask

  task automatic test_stuck_bit0();
    flt_word = 7; flt_mask = 32'h1;
`ifdef DM_BIST_BYTE_EN
    push_res(1'b0, 16'd3, 14'h1C, 32'h5A5A_A5A4);
`else
    push_res(1'b0, 16'd2, 14'h1C, 32'h5A5A_A5A4);
`endif
    run_march(-1, 1'b0);
  endtask

  task automatic test_restart_clears();
    flt_word = -1; flt_mask = '0;
    push_res(1'b1, 16'd0, 14'd0, 32'd0);
    run_march(-1, 1'b0);
  endtask

  task automatic test_ignored_start();
    push_res(1'b1, 16'd0, 14'd0, 32'd0);
    run_march(-1, 1'b1);
  endtask

  task automatic test_reset_midrun();
    flt_word = 2; flt_mask = 32'h1;
    run_march(20, 1'b0);
    n_cmp++;
    if (err_cnt !== 16'd1 || fail_addr !== 14'h08) begin
      n_bad++;
      $display("FAIL pre_reset_err: got err=%h fa=%h want err=1 fa=08", err_cnt, fail_addr);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, pass, err_cnt, fail_addr, fail_data, a, wdOp, wd, we} !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset: got busy=%b done=%b pass=%b err=%h fa=%h fd=%h a=%h op=%b wd=%h we=%b want all 0",
               busy, done, pass, err_cnt, fail_addr, fail_data, a, wdOp, wd, we);
    end
    acc_q.delete();
    flt_word = -1; flt_mask = '0;
    @(negedge clk);
    reset = 1'b1;
    push_res(1'b1, 16'd0, 14'd0, 32'd0);
    run_march(-1, 1'b0);
  endtask

`ifdef DM_BIST_BYTE_EN
  // Byte writes to 0x0E are dropped, so lane 2 of word 3 still holds P[23:16] from the word phase.
  task automatic test_byte_fault();
    flt_byte = 14;
    push_res(1'b0, 16'd1, 14'h0E, 32'h0000_005A);
    run_march(-1, 1'b0);
    flt_byte = -1;
    push_res(1'b1, 16'd0, 14'd0, 32'd0);
    run_march(-1, 1'b0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean();
    test_stuck_bit3();
    test_restart_clears();
    test_stuck_bit0();
    test_restart_clears();
    test_ignored_start();
    test_reset_midrun();
`ifdef DM_BIST_BYTE_EN
    test_byte_fault();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
